// File: rtl/sdram_axi_line_master.sv
// Cache-line AXI4 master: one line request becomes a single INCR burst of LINE_WORDS beats,
// followed by a one-cycle completion pulse carrying an error flag and the refill data.
module sdram_axi_line_master #(
  parameter int unsigned LINE_WORDS = 8,
  parameter logic [3:0]  AXI_ID     = 4'd0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  // Line request / response
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_write_i,
  input  logic [31:0]                req_addr_i,
  input  logic [LINE_WORDS*32-1:0]   req_wdata_i,
  output logic                       resp_valid_o,
  output logic                       resp_error_o,
  output logic [LINE_WORDS*32-1:0]   resp_rdata_o,
  // AXI4 write address
  output logic                       axi_awvalid_o,
  output logic [31:0]                axi_awaddr_o,
  output logic [3:0]                 axi_awid_o,
  output logic [7:0]                 axi_awlen_o,
  output logic [1:0]                 axi_awburst_o,
  input  logic                       axi_awready_i,
  // AXI4 write data
  output logic                       axi_wvalid_o,
  output logic [31:0]                axi_wdata_o,
  output logic [3:0]                 axi_wstrb_o,
  output logic                       axi_wlast_o,
  input  logic                       axi_wready_i,
  // AXI4 write response
  input  logic                       axi_bvalid_i,
  input  logic [1:0]                 axi_bresp_i,
  input  logic [3:0]                 axi_bid_i,
  output logic                       axi_bready_o,
  // AXI4 read address
  output logic                       axi_arvalid_o,
  output logic [31:0]                axi_araddr_o,
  output logic [3:0]                 axi_arid_o,
  output logic [7:0]                 axi_arlen_o,
  output logic [1:0]                 axi_arburst_o,
  input  logic                       axi_arready_i,
  // AXI4 read data
  input  logic                       axi_rvalid_i,
  input  logic [31:0]                axi_rdata_i,
  input  logic [1:0]                 axi_rresp_i,
  input  logic [3:0]                 axi_rid_i,
  input  logic                       axi_rlast_i,
  output logic                       axi_rready_o
);

  localparam int unsigned   IdxW    = $clog2(LINE_WORDS);
  localparam int unsigned   CntW    = IdxW + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(LINE_WORDS - 1);
  localparam logic [31:0]   OffMask = 32'(LINE_WORDS * 4 - 1);

  typedef enum logic [2:0] {StIdle, StAr, StR, StAw, StW, StB, StDone} state_e;

  state_e                       state_q, state_d;
  logic [31:0]                  addr_q, addr_d;
  logic [CntW-1:0]              cnt_q, cnt_d;
  logic                         err_q, err_d;
  logic [LINE_WORDS-1:0][31:0]  line_q, line_d;
  logic [IdxW-1:0]              idx;
  logic                         last_beat;
  logic                         unused_ids;

  assign idx        = cnt_q[IdxW-1:0];
  assign last_beat  = (cnt_q == LastCnt);
  assign unused_ids = ^{axi_bid_i, axi_rid_i};

  // Static channel attributes
  assign axi_awaddr_o  = addr_q;
  assign axi_araddr_o  = addr_q;
  assign axi_awid_o    = AXI_ID;
  assign axi_arid_o    = AXI_ID;
  assign axi_awlen_o   = 8'(LINE_WORDS - 1);
  assign axi_arlen_o   = 8'(LINE_WORDS - 1);
  assign axi_awburst_o = 2'b01;
  assign axi_arburst_o = 2'b01;
  assign axi_wstrb_o   = 4'hF;
  assign axi_wdata_o   = line_q[idx];
  assign axi_wlast_o   = last_beat;
  assign resp_rdata_o  = line_q;

  // Ready is masked by reset so it reads 0 while rst_ni is held low
  assign req_ready_o   = (state_q == StIdle) & rst_ni;

  always_comb begin
    axi_arvalid_o = 1'b0;
    axi_rready_o  = 1'b0;
    axi_awvalid_o = 1'b0;
    axi_wvalid_o  = 1'b0;
    axi_bready_o  = 1'b0;
    resp_valid_o  = 1'b0;
    resp_error_o  = 1'b0;
    unique case (state_q)
      StAr:    axi_arvalid_o = 1'b1;
      StR:     axi_rready_o  = 1'b1;
      StAw:    axi_awvalid_o = 1'b1;
      StW:     axi_wvalid_o  = 1'b1;
      StB:     axi_bready_o  = 1'b1;
      StDone: begin
        resp_valid_o = 1'b1;
        resp_error_o = err_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    line_d  = line_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i & ~OffMask;
          line_d  = req_wdata_i;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = req_write_i ? StAw : StAr;
        end
      end
      StAr: if (axi_arready_i) state_d = StR;
      StR: begin
        if (axi_rvalid_i) begin
          line_d[idx] = axi_rdata_i;
          if (axi_rresp_i != 2'b00) err_d = 1'b1;
          if (last_beat) begin
            if (!axi_rlast_i) err_d = 1'b1;
            state_d = StDone;
          end else if (axi_rlast_i) begin
            // Slave terminated the burst early
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StAw: if (axi_awready_i) state_d = StW;
      StW: begin
        if (axi_wready_i) begin
          if (last_beat) state_d = StB;
          else           cnt_d   = cnt_q + 1'b1;
        end
      end
      StB: begin
        if (axi_bvalid_i) begin
          if (axi_bresp_i != 2'b00) err_d = 1'b1;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      line_q  <= line_d;
    end
  end

endmodule
